// File: rtl/iic_arb.sv
// -----------------------------------------------------------------------------
// iic_arb
//
// Two-requester arbiter in front of a single shared IIC master. Each requester
// (A, B) fires a one-cycle trig with a command (read/write, 16-bit register
// address, write data, device id). The command is parked in a per-port request
// register until the arbiter issues it to the master, waits for the master's
// busy to rise and fall, and routes the read data back to the requester.
// After a transfer the grant lingers with the last owner for HOLD_CYC cycles so
// a requester issuing back-to-back transfers keeps the bus.
//
// Parameters
//   HOLD_CYC  cycles the grant stays with the last owner after completion
//   START_TO  cycles allowed for m_busy to rise after m_iic_trig
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   {a,b}_iic_trig                one-cycle transfer request
//   {a,b}_w_r                     1 = write, 0 = read
//   {a,b}_addr / _data_in         register address / write data
//   {a,b}_device_id               slave device address
//   {a,b}_busy                    requester busy view (registered)
//   {a,b}_data_out                last read data returned to the requester
//   {a,b}_byte_over               master's byte-complete pulse, owner only
//   m_iic_trig, m_w_r, m_addr,
//   m_data_in, m_device_id        command to the shared master
//   m_busy, m_data_out,
//   m_byte_over                   status from the shared master
//   owner                         0 = A, 1 = B; current or most recent grant
//   err_ovf, err_to               sticky: dropped trig / master start timeout
// -----------------------------------------------------------------------------
module iic_arb #(
    parameter int HOLD_CYC = 4,
    parameter int START_TO = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_iic_trig,
    input  logic        a_w_r,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_data_in,
    input  logic [7:0]  a_device_id,
    output logic        a_busy,
    output logic [7:0]  a_data_out,
    output logic        a_byte_over,

    input  logic        b_iic_trig,
    input  logic        b_w_r,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_data_in,
    input  logic [7:0]  b_device_id,
    output logic        b_busy,
    output logic [7:0]  b_data_out,
    output logic        b_byte_over,

    output logic        m_iic_trig,
    output logic        m_w_r,
    output logic [15:0] m_addr,
    output logic [7:0]  m_data_in,
    output logic [7:0]  m_device_id,
    input  logic        m_busy,
    input  logic [7:0]  m_data_out,
    input  logic        m_byte_over,

    output logic        owner,
    output logic        err_ovf,
    output logic        err_to
);

    // One counter serves both the start timeout and the hold window, so it is
    // sized for the larger of the two.
    localparam int CNT_MAX = (HOLD_CYC > START_TO) ? HOLD_CYC : START_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef struct packed {
        logic        w_r;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  dev;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WSTART,
        XFER,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;

    logic             a_pend_q, a_pend_d;
    logic             b_pend_q, b_pend_d;
    req_t             a_req_q, a_req_d;
    req_t             b_req_q, b_req_d;
    req_t             m_req_q, m_req_d;

    logic             a_busy_q, a_busy_d;
    logic             b_busy_q, b_busy_d;
    logic [7:0]       a_dout_q, a_dout_d;
    logic [7:0]       b_dout_q, b_dout_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_to_q, err_to_d;

    logic             own_pend;
    logic             clr_own;
    logic             cpl;
    logic             to_hit;
    logic             clr_a, clr_b;
    logic             acc_a, acc_b;
    logic             active_d;
    logic             fwd_bo;

    assign own_pend = owner_q ? b_pend_q : a_pend_q;

    // -------------------------------------------------------------------------
    // Arbitration state machine
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        clr_own = 1'b0;
        cpl     = 1'b0;
        to_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_pend_q || b_pend_q) begin
                    // Round-robin: on a tie the port that did not own last wins.
                    owner_d = (a_pend_q && b_pend_q) ? ~owner_q : b_pend_q;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                state_d = WSTART;
                cnt_d   = '0;
            end

            WSTART: begin
                if (m_busy) begin
                    state_d = XFER;
                end else if (cnt_q == START_LAST) begin
                    to_hit  = 1'b1;
                    clr_own = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            XFER: begin
                // XFER is only entered with m_busy high, so a low level here
                // is the falling edge of the transfer.
                if (!m_busy) begin
                    clr_own = 1'b1;
                    cpl     = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end

            HOLD: begin
                // The owner keeps the bus over a waiting peer while it re-requests
                // within the hold window.
                if (own_pend) begin
                    state_d = ISSUE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture, status and data return
    // -------------------------------------------------------------------------
    assign clr_a = clr_own & ~owner_q;
    assign clr_b = clr_own &  owner_q;

    // A trig landing in the same cycle its own pending clears is taken.
    assign acc_a = a_iic_trig & (~a_pend_q | clr_a);
    assign acc_b = b_iic_trig & (~b_pend_q | clr_b);

    assign active_d = (state_d == ISSUE) || (state_d == WSTART) || (state_d == XFER);

    always_comb begin
        a_pend_d = acc_a | (a_pend_q & ~clr_a);
        b_pend_d = acc_b | (b_pend_q & ~clr_b);

        a_req_d = a_req_q;
        if (acc_a) begin
            a_req_d.w_r  = a_w_r;
            a_req_d.addr = a_addr;
            a_req_d.data = a_data_in;
            a_req_d.dev  = a_device_id;
        end

        b_req_d = b_req_q;
        if (acc_b) begin
            b_req_d.w_r  = b_w_r;
            b_req_d.addr = b_addr;
            b_req_d.data = b_data_in;
            b_req_d.dev  = b_device_id;
        end

        // The master command is loaded on entry to ISSUE so it is already
        // valid in the trig cycle and then held until the next issue.
        m_req_d = m_req_q;
        if (state_d == ISSUE) begin
            m_req_d = owner_d ? b_req_q : a_req_q;
        end

        a_busy_d = a_pend_d | (active_d & ~owner_d);
        b_busy_d = b_pend_d | (active_d &  owner_d);

        a_dout_d = (cpl && !owner_q) ? m_data_out : a_dout_q;
        b_dout_d = (cpl &&  owner_q) ? m_data_out : b_dout_q;

        err_ovf_d = err_ovf_q | (a_iic_trig & ~acc_a) | (b_iic_trig & ~acc_b);
        err_to_d  = err_to_q  | to_hit;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b1;  // so A wins the first tie
            a_pend_q  <= 1'b0;
            b_pend_q  <= 1'b0;
            a_req_q   <= '0;
            b_req_q   <= '0;
            m_req_q   <= '0;
            a_busy_q  <= 1'b0;
            b_busy_q  <= 1'b0;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            a_pend_q  <= a_pend_d;
            b_pend_q  <= b_pend_d;
            a_req_q   <= a_req_d;
            b_req_q   <= b_req_d;
            m_req_q   <= m_req_d;
            a_busy_q  <= a_busy_d;
            b_busy_q  <= b_busy_d;
            a_dout_q  <= a_dout_d;
            b_dout_q  <= b_dout_d;
            err_ovf_q <= err_ovf_d;
            err_to_q  <= err_to_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Byte-complete is passed through only while a transfer is in flight;
    // activity seen in IDLE or HOLD belongs to nobody.
    assign fwd_bo = m_byte_over && ((state_q == WSTART) || (state_q == XFER));

    assign a_byte_over = fwd_bo & ~owner_q;
    assign b_byte_over = fwd_bo &  owner_q;

    assign m_iic_trig  = (state_q == ISSUE);
    assign m_w_r       = m_req_q.w_r;
    assign m_addr      = m_req_q.addr;
    assign m_data_in   = m_req_q.data;
    assign m_device_id = m_req_q.dev;

    assign a_busy      = a_busy_q;
    assign b_busy      = b_busy_q;
    assign a_data_out  = a_dout_q;
    assign b_data_out  = b_dout_q;
    assign owner       = owner_q;
    assign err_ovf     = err_ovf_q;
    assign err_to      = err_to_q;

endmodule
